// File: rtl/cnn_pkg.sv
// Shared CNN package: activation width, layer output sizes, bank ownership state.
// Imported by the activation ping-pong store and its bank sub-module.
package cnn_pkg;

    localparam int ACT_W   = 8;
    localparam int C1_OUT  = 4704;
    localparam int P1_OUT  = 1176;
    localparam int P2_OUT  = 400;
    localparam int FC1_OUT = 120;
    localparam int FC2_OUT = 84;

    typedef enum logic {
        BANK_EMPTY = 1'b0,
        BANK_FULL  = 1'b1
    } bank_st_e;

endpackage

// File: rtl/cnn_act_bank.sv
// Single activation bank: one write port, one read port, out-of-range safe.
// Macro CNN_ACT_RDREG_EN selects a registered (block-RAM) read path.
module cnn_act_bank
    import cnn_pkg::*;
#(
    parameter int DATA_W = ACT_W,
    parameter int DEPTH  = C1_OUT,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
`ifdef CNN_ACT_RDREG_EN
    input  logic              rst_n,
`endif
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_ok;
    logic              rd_ok;

    assign wr_ok = ({1'b0, waddr_i} < LIM);
    assign rd_ok = ({1'b0, raddr_i} < LIM);

    // Storage write; addresses beyond the bank are dropped
    always_ff @(posedge clk) begin
        if (we_i && wr_ok) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

`ifdef CNN_ACT_RDREG_EN
    logic [DATA_W-1:0] rdata_q;

    // Registered read, out-of-range addresses read as zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rd_ok ? mem_q[raddr_i] : '0;
        end
    end

    assign rdata_o = rdata_q;
`else
    assign rdata_o = rd_ok ? mem_q[raddr_i] : '0;
`endif

endmodule

// File: rtl/cnn_act_pingpong.sv
// Double-buffered activation store between two CNN layer engines.
// Macro CNN_ACT_RDREG_EN: registered read with one cycle of latency.
module cnn_act_pingpong
    import cnn_pkg::*;
#(
    parameter int DATA_W = ACT_W,
    parameter int DEPTH  = C1_OUT,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_commit,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              rd_release,
    output logic              rd_valid,
    output logic              wr_sel,
    output logic              rd_sel,
    output logic [1:0]        err
);

    bank_st_e          state_q [2];
    bank_st_e          state_d [2];
    logic              wr_sel_q, wr_sel_d;
    logic              rd_sel_q, rd_sel_d;
    logic [1:0]        err_q, err_d;
    logic              do_commit;
    logic              do_release;
    logic [DATA_W-1:0] bank_rdata [2];

    assign wr_ready   = (state_q[wr_sel_q] == BANK_EMPTY);
    assign rd_valid   = (state_q[rd_sel_q] == BANK_FULL);
    assign do_commit  = wr_commit & wr_ready;
    assign do_release = rd_release & rd_valid;
    assign wr_sel     = wr_sel_q;
    assign rd_sel     = rd_sel_q;
    assign err        = err_q;

    // Ownership next state; commit and release judged on pre-edge state
    always_comb begin
        state_d  = state_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        if (do_commit) begin
            state_d[wr_sel_q] = BANK_FULL;
            wr_sel_d          = ~wr_sel_q;
        end
        if (do_release) begin
            state_d[rd_sel_q] = BANK_EMPTY;
            rd_sel_d          = ~rd_sel_q;
        end
        err_d = err_q | {rd_release & ~rd_valid,
                         (wr_en | wr_commit) & ~wr_ready};
    end

    // Ownership and sticky error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q[0] <= BANK_EMPTY;
            state_q[1] <= BANK_EMPTY;
            wr_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            err_q      <= 2'b00;
        end else begin
            state_q    <= state_d;
            wr_sel_q   <= wr_sel_d;
            rd_sel_q   <= rd_sel_d;
            err_q      <= err_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        cnn_act_bank #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk     (clk),
`ifdef CNN_ACT_RDREG_EN
            .rst_n   (rst_n),
`endif
            .we_i    (wr_en & wr_ready & (wr_sel_q == 1'(b))),
            .waddr_i (wr_addr),
            .wdata_i (wr_data),
            .raddr_i (rd_addr),
            .rdata_o (bank_rdata[b])
        );
    end

`ifdef CNN_ACT_RDREG_EN
    logic rd_sel_r_q;

    // Bank select that matches the registered read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_sel_r_q <= 1'b0;
        end else begin
            rd_sel_r_q <= rd_sel_q;
        end
    end

    assign rd_data = bank_rdata[rd_sel_r_q];
`else
    assign rd_data = bank_rdata[rd_sel_q];
`endif

endmodule

// File: tb/tb_cnn_act_pingpong.sv
// Self-checking bench for cnn_act_pingpong.
// Read data flows through an expected-value queue.
module tb_cnn_act_pingpong;
    import cnn_pkg::*;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4704;
    localparam int ADDR_W = 13;

    logic              clk;
    logic              rst_n;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_commit;
    logic              wr_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_release;
    logic              rd_valid;
    logic              wr_sel;
    logic              rd_sel;
    logic [1:0]        err;

    int n_cmp = 0;
    int n_err = 0;
    logic [DATA_W-1:0] exp_q [$];

    cnn_act_pingpong #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_commit  (wr_commit),
        .wr_ready   (wr_ready),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_release (rd_release),
        .rd_valid   (rd_valid),
        .wr_sel     (wr_sel),
        .rd_sel     (rd_sel),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_st(input string tag, input logic wrdy,
                          input logic rv, input logic ws,
                          input logic rs, input logic [1:0] e);
        check({tag, ".wr_ready"}, 32'(wr_ready), 32'(wrdy));
        check({tag, ".rd_valid"}, 32'(rd_valid), 32'(rv));
        check({tag, ".wr_sel"},   32'(wr_sel),   32'(ws));
        check({tag, ".rd_sel"},   32'(rd_sel),   32'(rs));
        check({tag, ".err"},      32'(err),      32'(e));
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(a);
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic commit();
        wr_commit = 1'b1;
        tick();
        wr_commit = 1'b0;
    endtask

    task automatic release_bank();
        rd_release = 1'b1;
        tick();
        rd_release = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic rd_chk(input string tag, input int a,
                          input logic [7:0] exp);
        rd_addr = ADDR_W'(a);
        exp_q.push_back(exp);
`ifdef CNN_ACT_RDREG_EN
        tick();
`else
        #1;
`endif
        check(tag, 32'(rd_data), 32'(exp_q.pop_front()));
    endtask

    initial begin
        rst_n      = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        wr_commit  = 1'b0;
        rd_addr    = '0;
        rd_release = 1'b0;
        #2;
        chk_st("rst", 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
`ifdef CNN_ACT_RDREG_EN
        check("rst.rd_data", 32'(rd_data), 32'h0);
`endif
        tick();
        rst_n = 1'b1;

        // fill bank0, swap, read back
        for (int i = 0; i < 4; i++) wr(i, 8'h11 + 8'(i));
        commit();
        chk_st("fill", 1'b1, 1'b1, 1'b1, 1'b0, 2'b00);
        rd_chk("fill.a2", 2, 8'h13);
        rd_chk("fill.a0", 0, 8'h11);

        // both banks full: producer stalls
        for (int i = 0; i < 4; i++) wr(i, 8'h21 + 8'(i));
        commit();
        chk_st("ovl", 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        wr(2, 8'hEE);
        chk_st("ovl.err", 1'b0, 1'b1, 1'b0, 1'b0, 2'b01);
        rd_chk("ovl.b0a2", 2, 8'h13);
        release_bank();
        chk_st("ovl.rel", 1'b1, 1'b1, 1'b0, 1'b1, 2'b01);
        rd_chk("ovl.b1a2", 2, 8'h23);
        rd_chk("ovl.b1a3", 3, 8'h24);

        // simultaneous commit, release and write
        do_reset();
        for (int i = 0; i < 4; i++) wr(i, 8'h31 + 8'(i));
        commit();
        for (int i = 0; i < 3; i++) wr(i, 8'h41 + 8'(i));
        wr_en      = 1'b1;
        wr_addr    = ADDR_W'(3);
        wr_data    = 8'h44;
        wr_commit  = 1'b1;
        rd_release = 1'b1;
        tick();
        wr_en      = 1'b0;
        wr_commit  = 1'b0;
        rd_release = 1'b0;
        chk_st("sim", 1'b1, 1'b1, 1'b0, 1'b1, 2'b00);
        rd_chk("sim.a3", 3, 8'h44);
        rd_chk("sim.a0", 0, 8'h41);

        // bad release and out-of-range accesses
        do_reset();
        release_bank();
        chk_st("badrel", 1'b1, 1'b0, 1'b0, 1'b0, 2'b10);
        for (int i = 0; i < 4; i++) wr(i, 8'h51 + 8'(i));
        wr(DEPTH, 8'hAA);
        wr(8191, 8'hBB);
        commit();
        chk_st("oor", 1'b1, 1'b1, 1'b1, 1'b0, 2'b10);
        for (int i = 0; i < 4; i++) rd_chk("oor.a", i, 8'h51 + 8'(i));
        rd_chk("oor.rd", DEPTH, 8'h00);
        rd_chk("oor.rdmax", 8191, 8'h00);

        // async reset mid-fill, off the clock edge
        do_reset();
        wr(0, 8'h61);
        commit();
        wr(0, 8'h62);
        release_bank();
        release_bank();
        wr(1, 8'h63);
        chk_st("pre", 1'b1, 1'b0, 1'b1, 1'b1, 2'b10);
        #3;
        rst_n = 1'b0;
        #1;
        chk_st("arst", 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) wr(i, 8'h71 + 8'(i));
        commit();
        chk_st("refill", 1'b1, 1'b1, 1'b1, 1'b0, 2'b00);
        for (int i = 0; i < 4; i++) rd_chk("refill.a", i, 8'h71 + 8'(i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
